// File: rtl/ram_wr_buffer.sv
// ram_wr_buffer: posted-write FIFO feeding a RAM write port, with read-address snoop for RAW forwarding.
// Optional WRBUF_COALESCE_EN merges a push into the youngest entry when the addresses match.
module ram_wr_buffer #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 4
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [ADDR_W-1:0]          req_addr,
    input  logic [DATA_W-1:0]          req_data,
    input  logic                       drain_en,
    output logic                       write,
    output logic [ADDR_W-1:0]          wr_address,
    output logic [DATA_W-1:0]          data_in,
    output logic [$clog2(DEPTH+1)-1:0] level,
    input  logic [ADDR_W-1:0]          rd_address,
    output logic                       rd_hit,
    output logic [DATA_W-1:0]          rd_hit_data
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ADDR_W-1:0] addr_d [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [PW-1:0]     rptr_q, rptr_d, wptr_q, wptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] wr_address_q, wr_address_d;
    logic [DATA_W-1:0] data_in_q, data_in_d;
    logic              empty, full, coal_hit, push, pop, coalesce, alloc;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            valid_q      <= '0;
            rptr_q       <= '0;
            wptr_q       <= '0;
            level_q      <= '0;
            write_q      <= 1'b0;
            wr_address_q <= '0;
            data_in_q    <= '0;
        end else begin
            addr_q       <= addr_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            rptr_q       <= rptr_d;
            wptr_q       <= wptr_d;
            level_q      <= level_d;
            write_q      <= write_d;
            wr_address_q <= wr_address_d;
            data_in_q    <= data_in_d;
        end
    end

    always_comb begin
        empty = (level_q == '0);
        full  = (level_q == LW'(DEPTH));
`ifdef WRBUF_COALESCE_EN
        coal_hit = !empty && (addr_q[wptr_q - PW'(1)] == req_addr);
`else
        coal_hit = 1'b0;
`endif
        // readiness never looks at pop, so a full buffer refuses even while draining
        req_ready    = resetn && (!full || coal_hit);
        push         = req_valid && req_ready;
        pop          = !empty && drain_en;
        coalesce     = push && coal_hit && !(pop && level_q == LW'(1));
        alloc        = push && !coalesce;
        addr_d       = addr_q;
        data_d       = data_q;
        valid_d      = valid_q;
        rptr_d       = rptr_q;
        wptr_d       = wptr_q;
        write_d      = pop;
        wr_address_d = pop ? addr_q[rptr_q] : wr_address_q;
        data_in_d    = pop ? data_q[rptr_q] : data_in_q;
        if (pop) begin
            valid_d[rptr_q] = 1'b0;
            rptr_d          = rptr_q + PW'(1);
        end
        if (coalesce)
            data_d[wptr_q - PW'(1)] = req_data;
        if (alloc) begin
            addr_d[wptr_q]  = req_addr;
            data_d[wptr_q]  = req_data;
            valid_d[wptr_q] = 1'b1;
            wptr_d          = wptr_q + PW'(1);
        end
        level_d = level_q + LW'(alloc) - LW'(pop);
    end

    // scan oldest to youngest so the youngest match wins; the output register ranks lowest
    always_comb begin
        rd_hit      = write_q && (wr_address_q == rd_address);
        rd_hit_data = rd_hit ? data_in_q : '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[rptr_q + PW'(i)] && addr_q[rptr_q + PW'(i)] == rd_address) begin
                rd_hit      = 1'b1;
                rd_hit_data = data_q[rptr_q + PW'(i)];
            end
        end
    end

    assign write      = write_q;
    assign wr_address = wr_address_q;
    assign data_in    = data_in_q;
    assign level      = level_q;
endmodule
